// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline memory stage: word/byte loads and stores
// against an internal array with a fixed number of wait states per access.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int WAIT_INIT_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0] WAIT_INIT = WAIT_INIT_I[3:0];

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;

    // request captured at acceptance
    logic        rd_p0, wr_p0, type_p0;
    logic [31:0] addr_p0, wdata_p0;

    logic        sel_rd, sel_wr, sel_type;
    logic [31:0] sel_addr, sel_wdata;
    logic [AW-1:0] idx;
    logic [1:0]  lane;
    logic        bad;
    logic        pending, accept, enter_done, commit;
    logic        err_q;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic        unused_addr_bits;

    logic [31:0] mem [DEPTH_WORDS];

    function automatic logic signed [31:0] sext_byte(input logic signed [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    assign pending = mem_read | mem_write;
    assign accept  = (state == IDLE) && pending;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (pending) begin
                    if (WAIT_STATES > 0) begin
                        state_nx = WAIT;
                        cnt_nx   = WAIT_INIT;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nx = DONE;
                else             cnt_nx   = cnt - 4'd1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rd_p0    <= mem_read;
            wr_p0    <= mem_write;
            type_p0  <= mem_type;
            addr_p0  <= addr;
            wdata_p0 <= wdata;
        end
    end

    // With zero wait states the access completes straight from IDLE, so the live inputs are used.
    always_comb begin
        if (state == IDLE) begin
            sel_rd    = mem_read;
            sel_wr    = mem_write;
            sel_type  = mem_type;
            sel_addr  = addr;
            sel_wdata = wdata;
        end else begin
            sel_rd    = rd_p0;
            sel_wr    = wr_p0;
            sel_type  = type_p0;
            sel_addr  = addr_p0;
            sel_wdata = wdata_p0;
        end
    end

    assign idx  = sel_addr[AW+1:2];
    assign lane = sel_addr[1:0];
    assign bad  = (!sel_type && lane != 2'd0) || (sel_rd && sel_wr);
    assign unused_addr_bits = ^sel_addr[31:AW+2];

    assign enter_done = (state_nx == DONE) && (state != DONE);
    assign commit     = enter_done && !reset;

    assign rd_word = mem[idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (commit && sel_wr && !bad) begin
            if (sel_type) mem[idx][{lane, 3'b000} +: 8] <= sel_wdata[7:0];
            else          mem[idx] <= sel_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= 32'd0;
            err_q <= 1'b0;
        end else if (enter_done) begin
            err_q <= bad;
            if (bad) begin
                if (sel_rd) rdata <= 32'd0;
            end else if (sel_rd) begin
                rdata <= sel_type ? sext_byte(rd_byte) : rd_word;
            end
        end
    end

    assign ready = (state == DONE) && !reset;
    assign err   = ready && err_q;
    assign stall = !reset && (((state == IDLE) && pending) || (state == WAIT));

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_read, mem_write, mem_type;
    logic [31:0] addr, wdata, rdata;
    logic        ready, stall, err;

    logic        z_reset, z_mem_read, z_mem_write, z_mem_type;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic        z_ready, z_stall, z_err;

    int n_checks = 0;
    int n_errors = 0;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_type(mem_type), .addr(addr), .wdata(wdata), .rdata(rdata),
        .ready(ready), .stall(stall), .err(err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(z_reset), .mem_read(z_mem_read), .mem_write(z_mem_write),
        .mem_type(z_mem_type), .addr(z_addr), .wdata(z_wdata), .rdata(z_rdata),
        .ready(z_ready), .stall(z_stall), .err(z_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access on the two-wait-state instance; called at posedge+1 with the DUT idle.
    task automatic access(input string tag, input logic rd, input logic wr, input logic typ,
                          input logic [31:0] a, input logic [31:0] d, input logic exp_err);
        int   lat    = 0;
        int   stalls = 0;
        logic e      = 1'b0;
        mem_read = rd; mem_write = wr; mem_type = typ; addr = a; wdata = d;
        #1;
        if (stall) stalls++;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                mem_read = 1'b0; mem_write = 1'b0; mem_type = ~typ;
                addr = 32'hFFFF_FFFC; wdata = 32'h0;
            end
            if (ready) begin
                lat = n;
                e   = err;
                break;
            end
            if (stall) stalls++;
        end
        check({tag, " latency"}, 32'(lat), 32'd3);
        check({tag, " stalls"}, 32'(stalls), 32'd3);
        check({tag, " err"}, 32'(e), 32'(exp_err));
        @(posedge clk); #1;
        check({tag, " ready width"}, 32'(ready), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [5:0] rdy_bits;
        logic [5:0] stl_bits;

        reset = 1'b1; mem_read = 0; mem_write = 0; mem_type = 0; addr = 0; wdata = 0;
        z_reset = 1'b1; z_mem_read = 0; z_mem_write = 0; z_mem_type = 0; z_addr = 0; z_wdata = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset rdata", rdata, 32'h0);
        check("reset ready", 32'(ready), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        check("reset z_rdata", z_rdata, 32'h0);
        reset = 1'b0; z_reset = 1'b0;
        @(posedge clk); #1;

        access("st w 0x10", 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        access("ld w 0x10", 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
        check("ld w 0x10 rdata", rdata, 32'hDEADBEEF);

        access("st w 0x20", 1'b0, 1'b1, 1'b0, 32'h20, 32'h11223344, 1'b0);
        access("st b 0x21", 1'b0, 1'b1, 1'b1, 32'h21, 32'hAAAAAA80, 1'b0);
        access("st b 0x22", 1'b0, 1'b1, 1'b1, 32'h22, 32'h5555557F, 1'b0);
        check("store keeps rdata", rdata, 32'hDEADBEEF);
        access("ld w 0x20", 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
        check("ld w 0x20 rdata", rdata, 32'h117F8044);
        access("ld b 0x21", 1'b1, 1'b0, 1'b1, 32'h21, 32'h0, 1'b0);
        check("ld b 0x21 rdata", rdata, 32'hFFFFFF80);
        access("ld b 0x22", 1'b1, 1'b0, 1'b1, 32'h22, 32'h0, 1'b0);
        check("ld b 0x22 rdata", rdata, 32'h0000007F);

        access("ld w 0x06", 1'b1, 1'b0, 1'b0, 32'h06, 32'h0, 1'b1);
        check("misaligned rdata", rdata, 32'h0);
        access("st w 0x04", 1'b0, 1'b1, 1'b0, 32'h04, 32'hCAFEF00D, 1'b0);
        access("st w 0x06", 1'b0, 1'b1, 1'b0, 32'h06, 32'h12345678, 1'b1);
        access("ld w 0x04", 1'b1, 1'b0, 1'b0, 32'h04, 32'h0, 1'b0);
        check("ld w 0x04 rdata", rdata, 32'hCAFEF00D);
        access("rw w 0x04", 1'b1, 1'b1, 1'b0, 32'h04, 32'h0BADBAD0, 1'b1);
        check("mixed rdata", rdata, 32'h0);
        access("ld w 0x04 again", 1'b1, 1'b0, 1'b0, 32'h04, 32'h0, 1'b0);
        check("mem unchanged", rdata, 32'hCAFEF00D);

        access("st w 0x400", 1'b0, 1'b1, 1'b0, 32'h400, 32'hA5A5A5A5, 1'b0);
        access("ld w 0x0", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("wrap rdata", rdata, 32'hA5A5A5A5);

        // Reset in the second wait cycle of a store must abandon it.
        access("st w 0x30", 1'b0, 1'b1, 1'b0, 32'h30, 32'h13579BDF, 1'b0);
        mem_write = 1'b1; mem_type = 1'b0; addr = 32'h30; wdata = 32'hFFFF0000;
        @(posedge clk); #1;
        mem_write = 1'b0; addr = 32'h0; wdata = 32'h0;
        check("abort wait1 ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort rst stall", 32'(stall), 32'd0);
        check("abort rst ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort ready", 32'(ready), 32'd0);
        check("abort rdata", rdata, 32'h0);
        @(posedge clk); #1;
        check("abort idle ready", 32'(ready), 32'd0);
        check("abort idle stall", 32'(stall), 32'd0);
        access("ld w 0x30", 1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 1'b0);
        check("abort kept mem", rdata, 32'h13579BDF);

        // Request held through reset is taken on the first edge with reset low.
        reset = 1'b1; mem_read = 1'b1; mem_type = 1'b0; addr = 32'h10;
        @(posedge clk); #1;
        check("held req rst stall", 32'(stall), 32'd0);
        reset = 1'b0;
        access("held ld 0x10", 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
        check("held ld rdata", rdata, 32'hDEADBEEF);

        // Zero wait states, request held continuously.
        z_mem_write = 1'b1; z_mem_type = 1'b0; z_addr = 32'h8; z_wdata = 32'h55AA55AA;
        #1;
        check("ws0 accept stall", 32'(z_stall), 32'd1);
        check("ws0 accept ready", 32'(z_ready), 32'd0);
        rdy_bits = '0;
        stl_bits = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            rdy_bits[i] = z_ready;
            stl_bits[i] = z_stall;
            if (i == 5) z_mem_write = 1'b0;
        end
        check("ws0 ready pattern", 32'(rdy_bits), 32'h15);
        check("ws0 stall pattern", 32'(stl_bits), 32'h2A);
        @(posedge clk); #1;
        check("ws0 idle ready", 32'(z_ready), 32'd0);
        z_mem_read = 1'b1; z_addr = 32'h8;
        @(posedge clk); #1;
        z_mem_read = 1'b0;
        check("ws0 ld ready", 32'(z_ready), 32'd1);
        check("ws0 ld rdata", z_rdata, 32'h55AA55AA);
        @(posedge clk); #1;
        z_mem_read = 1'b1; z_addr = 32'h9;
        @(posedge clk); #1;
        z_mem_read = 1'b0;
        check("ws0 err ready", 32'(z_ready), 32'd1);
        check("ws0 err", 32'(z_err), 32'd1);
        check("ws0 err rdata", z_rdata, 32'h0);
        @(posedge clk); #1;
        check("ws0 err width", 32'(z_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
